// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam logic [NUM_COLS-1:0] COLS_IDLE = 4'hF;

  // Active-low one-hot row drive for a row index.
  function automatic logic [NUM_ROWS-1:0] row_onehot_n(input logic [1:0] idx);
    logic [NUM_ROWS-1:0] r;
    r = '1;
    r[idx] = 1'b0;
    return r;
  endfunction

  // Index of the lowest closed (zero) column; column 0 has priority.
  function automatic logic [1:0] lowest_zero(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side bundle: synchronized columns in, row drive and key report out.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic [NUM_COLS-1:0] cols_sync;
  logic [NUM_ROWS-1:0] rows;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;

  // master: the scan controller
  modport master (input cols_sync, output rows, key_code, key_valid, key_held);
  // slave: the keypad/synchronizer side and the key consumer
  modport slave  (output cols_sync, input rows, key_code, key_valid, key_held);
endinterface

// File: rtl/debounce_counter.sv
// Counts consecutive enabled cycles; done flags DEBOUNCE_CYCLES-1 reached.
// Shared by press and release qualification.
module debounce_counter #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Stable-cycle counter: cleared on any break, holds once the target is hit.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en && !done) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign done = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates an active-low row, qualifies a press and its
// release with a shared debounce counter, reports one pulse per accepted key.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROW_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scan_ctrl_if.master kp
);

  localparam int RC_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(ROW_CYCLES - 1);

  scan_state_t     state_reg, state_next;
  logic [1:0]      row_idx_reg, row_idx_next;
  logic [1:0]      col_idx_reg, col_idx_next;
  logic [RC_W-1:0] row_cnt_reg, row_cnt_next;
  logic [3:0]      rows_reg, rows_next;
  logic [3:0]      key_code_reg, key_code_next;
  logic            key_valid_reg, key_valid_next;
  logic            key_held_reg, key_held_next;

  logic col_bit;
  logic db_en;
  logic db_clr;
  logic db_done;

  // Level of the column being qualified (1 = open).
  assign col_bit = kp.cols_sync[col_idx_reg];

  // The counter advances only while the watched column sits at the level
  // being qualified; any break (or any other state) restarts it from 0.
  assign db_en  = ((state_reg == DEBOUNCE) && !col_bit) ||
                  ((state_reg == RELEASE)  &&  col_bit);
  assign db_clr = !db_en;

  debounce_counter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .clr   (db_clr),
    .en    (db_en),
    .done  (db_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      row_cnt_reg   <= '0;
      rows_reg      <= row_onehot_n(2'd0);
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      row_cnt_reg   <= row_cnt_next;
      rows_reg      <= rows_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  // Next-state logic: scan, qualify press, hold, qualify release.
  always_comb begin
    state_next     = state_reg;
    row_idx_next   = row_idx_reg;
    col_idx_next   = col_idx_reg;
    row_cnt_next   = row_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    case (state_reg)
      SCAN: begin
        if (row_cnt_reg == ROW_LAST) begin
          row_cnt_next = '0;
          if (kp.cols_sync != COLS_IDLE) begin
            // Row stays driven while the press is qualified.
            col_idx_next = lowest_zero(kp.cols_sync);
            state_next   = DEBOUNCE;
          end else begin
            row_idx_next = row_idx_reg + 2'd1;
          end
        end else begin
          row_cnt_next = row_cnt_reg + RC_W'(1);
        end
      end

      DEBOUNCE: begin
        if (col_bit) begin
          // Bounce: resume scanning the same row from the start.
          state_next   = SCAN;
          row_cnt_next = '0;
        end else if (db_done) begin
          state_next     = HELD;
          key_code_next  = {row_idx_reg, col_idx_reg};
          key_valid_next = 1'b1;
          key_held_next  = 1'b1;
        end
      end

      HELD: begin
        // Only the accepted column is watched; other keys are ignored.
        if (col_bit) state_next = RELEASE;
      end

      RELEASE: begin
        if (!col_bit) begin
          state_next = HELD;
        end else if (db_done) begin
          state_next    = SCAN;
          key_held_next = 1'b0;
          row_idx_next  = row_idx_reg + 2'd1;
          row_cnt_next  = '0;
        end
      end

      default: state_next = SCAN;
    endcase

    rows_next = row_onehot_n(row_idx_next);
  end

  assign kp.rows      = rows_reg;
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 matrix keypad. Drives one active-low row at a time and reads the column lines after they pass through the team's 2-flop column synchronizer. Debounces press and release, then emits a one-cycle key_valid pulse with a 4-bit key code. Sits between the synchronizer output and the display/key-history logic.

Parameters:
ROW_CYCLES, 4, cycles each row is driven before columns are sampled; must be >= 3 to cover the 2-cycle synchronizer latency plus 1 settle cycle
DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a press or a release; benches override with 8
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cols_sync  input  4  synchronized column lines, active-low (0 = key closed)
rows  output  4  row drive, active-low one-hot (exactly one bit 0 at all times)
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high while the accepted key remains pressed (until release debounce completes)

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values: rows=4'b1110 (row 0), key_code=4'h0, key_valid=0, key_held=0, state=SCAN, row_idx=0, all counters 0.
- Reset asserted mid-operation takes effect at the next edge from any state. No key_valid is issued.
- All outputs are registered.
- Idle column pattern is 4'hF.
- SCAN:
  - Row counter runs 0..ROW_CYCLES-1 for the current row.
  - At count ROW_CYCLES-1, if cols_sync != 4'hF:
    - capture col_idx = index of the lowest zero bit (priority to col 0);
    - go to DEBOUNCE with rows held and debounce count 0.
  - Otherwise row_idx increments, wrapping 3->0; rows updates on the same edge; row counter clears.
- DEBOUNCE:
  - While cols_sync[col_idx]==0, the counter increments.
  - If cols_sync[col_idx]==1 at any cycle, return to SCAN on the same row with row counter 0. No pulse.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the column still low, go to HELD on the next edge.
  - On that same edge: key_code <= {row_idx, col_idx}, key_valid <= 1, key_held <= 1.
- HELD:
  - key_valid returns to 0 after exactly one cycle.
  - rows stays fixed; other columns and rows are ignored (no ghost or second key).
  - If cols_sync[col_idx]==1, go to RELEASE with count 0.
- RELEASE:
  - While cols_sync[col_idx]==1, the counter increments.
  - If the column goes low again, return to HELD. No new pulse, key_held stays 1.
  - At DEBOUNCE_CYCLES-1, on the next edge: key_held <= 0, go to SCAN, row_idx advances (wrap), row counter clears.
- key_code holds its value until the next accepted key.
- key_valid is never high for 2 consecutive cycles.
- Minimum press-to-pulse latency from the row sample: DEBOUNCE_CYCLES + 1 cycles.

Decomposition:
- Shared package keypad_pkg:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;
  - NUM_ROWS=4, NUM_COLS=4, COLS_IDLE=4'hF;
  - function row_onehot_n(idx) returning the active-low one-hot row drive.
- One sub-module is natural: debounce_counter (inputs clk, reset, clr, en; output done at DEBOUNCE_CYCLES-1). It is reused for both press and release.
- Row counter and FSM stay in the top module.

Test Plan:
(All scenarios use ROW_CYCLES=4, DEBOUNCE_CYCLES=8; the bench models the keypad plus the 2-flop synchronizer.)
1. Idle scan:
   - Stimulus: reset=1 for 2 cycles, then 0; cols idle 4'hF.
   - Required response: rows=4'b1110 during reset; rows cycles 1110->1101->1011->0111->1110, each held 4 cycles; key_valid=0 and key_held=0 throughout.
2. Clean press:
   - Stimulus: close row 2 / col 1 (cols_sync=4'b1101 whenever rows==4'b1011), held.
   - Required response: exactly one key_valid pulse with key_code=4'h9; key_held=1 from that cycle; rows stays 4'b1011.
3. Press bounce:
   - Stimulus: on row 2 / col 1, close for 3 cycles, open 1, close 3, then open.
   - Required response: no key_valid; scanning resumes and rows keeps rotating.
4. Release:
   - Stimulus: after scenario 2, open col 1 for 3 cycles, close again, then open for 8+ cycles.
   - Required response: key_held stays 1 through the glitch with no second pulse; after 8 stable open cycles key_held=0 and the next rows value is 4'b0111.
5. Ghost / simultaneous keys:
   - Stimulus: while row2/col1 is held, also close col 3 (cols_sync=4'b0101); separately, press cols 0 and 2 together on row 0.
   - Required response: no extra key_valid while held; the simultaneous press yields key_code=4'h0 (lowest column wins).
6. Reset mid-debounce:
   - Stimulus: assert reset for 1 cycle at debounce count 5.
   - Required response: next cycle rows=4'b1110, key_held=0, key_code=4'h0, and no key_valid pulse at any point.
